// File: rtl/fastram_bridge.sv
// rtl/fastram_bridge.sv - fast-RAM to SDRAM req/ack bridge with posted-write buffer and watchdog
//
// Converts strobe-qualified CPU fast-RAM accesses into a level sd_req/sd_ack
// handshake, holds read data for the core, and stalls the core via cpu_wait
// while an access is outstanding. A watchdog aborts requests that never ack.
//
// Optional feature macro: FASTRAM_WRITE_POST_EN
//   defined   - one-entry posted-write buffer with read-after-write forwarding
//   undefined - every write stalls the core until its ack
//
// Ports:
//   clk_sys, reset           clock, synchronous active-low reset
//   strobe, cpu_ce, cpu_we   memory-phase pulse, select, write enable
//   cpu_addr, cpu_wdata      access address / write data
//   cpu_rdata, cpu_wait      held read data, stall request
//   sd_req, sd_we, sd_addr,  SDRAM request (held until ack) and its
//   sd_wdata                 type / address / data, stable while sd_req=1
//   sd_ack, sd_rdata         one-cycle completion pulse and read data
//   timeout_err              sticky watchdog-abort flag
module fastram_bridge #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              strobe,
  input  logic              cpu_ce,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_wait,
  output logic              sd_req,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_wdata,
  input  logic              sd_ack,
  input  logic [7:0]        sd_rdata,
  output logic              timeout_err
);

`ifdef FASTRAM_WRITE_POST_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WR, RD, WR_RD} state_t;

  state_t              state, state_n;
  logic                wb_valid, wb_valid_n;
  logic [ADDR_W-1:0]   wb_addr, wb_addr_n;
  logic [7:0]          wb_data, wb_data_n;
  // Holds a write stalled behind the buffer (WR) or the read deferred by WR_RD.
  logic                pend_valid, pend_valid_n;
  logic [ADDR_W-1:0]   pend_addr, pend_addr_n;
  logic [7:0]          pend_data, pend_data_n;
  logic [15:0]         wd_cnt, wd_cnt_n;
  logic [7:0]          cpu_rdata_n;
  logic                cpu_wait_n, sd_req_n, sd_we_n, err_n;
  logic [ADDR_W-1:0]   sd_addr_n;
  logic [7:0]          sd_wdata_n;
  logic                accept;

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      state       <= IDLE;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= 8'h00;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= 8'h00;
      wd_cnt      <= 16'd0;
      cpu_rdata   <= 8'h00;
      cpu_wait    <= 1'b0;
      sd_req      <= 1'b0;
      sd_we       <= 1'b0;
      sd_addr     <= '0;
      sd_wdata    <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      wb_valid    <= wb_valid_n;
      wb_addr     <= wb_addr_n;
      wb_data     <= wb_data_n;
      pend_valid  <= pend_valid_n;
      pend_addr   <= pend_addr_n;
      pend_data   <= pend_data_n;
      wd_cnt      <= wd_cnt_n;
      cpu_rdata   <= cpu_rdata_n;
      cpu_wait    <= cpu_wait_n;
      sd_req      <= sd_req_n;
      sd_we       <= sd_we_n;
      sd_addr     <= sd_addr_n;
      sd_wdata    <= sd_wdata_n;
      timeout_err <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    wb_valid_n   = wb_valid;
    wb_addr_n    = wb_addr;
    wb_data_n    = wb_data;
    pend_valid_n = pend_valid;
    pend_addr_n  = pend_addr;
    pend_data_n  = pend_data;
    wd_cnt_n     = wd_cnt;
    cpu_rdata_n  = cpu_rdata;
    cpu_wait_n   = cpu_wait;
    sd_req_n     = sd_req;
    sd_we_n      = sd_we;
    sd_addr_n    = sd_addr;
    sd_wdata_n   = sd_wdata;
    err_n        = timeout_err;
    accept       = strobe && cpu_ce && !cpu_wait;

    // Completion or watchdog abort of the live request comes first; an ack
    // with sd_req low belongs to an abandoned request and is ignored.
    if (sd_req) begin
      if (sd_ack) begin
        sd_req_n = 1'b0;
        case (state)
          RD: begin
            cpu_rdata_n = sd_rdata;
            cpu_wait_n  = 1'b0;
            state_n     = IDLE;
          end
          WR_RD: begin
            wb_valid_n = 1'b0;
            sd_we_n    = 1'b0;
            sd_addr_n  = pend_addr;
            state_n    = RD;
          end
          WR: begin
            cpu_wait_n = 1'b0;
            if (pend_valid) begin
              // Stalled write moves into the buffer; it launches after the gap.
              wb_addr_n    = pend_addr;
              wb_data_n    = pend_data;
              sd_addr_n    = pend_addr;
              sd_wdata_n   = pend_data;
              sd_we_n      = 1'b1;
              pend_valid_n = 1'b0;
            end else begin
              wb_valid_n = 1'b0;
              state_n    = IDLE;
            end
          end
          default: ;
        endcase
      end else if (wd_cnt == 16'(TIMEOUT - 1)) begin
        sd_req_n     = 1'b0;
        wb_valid_n   = 1'b0;
        pend_valid_n = 1'b0;
        cpu_wait_n   = 1'b0;
        err_n        = 1'b1;
        state_n      = IDLE;
        if (state == RD || state == WR_RD) cpu_rdata_n = 8'hFF;
      end else begin
        wd_cnt_n = wd_cnt + 16'd1;
      end
    end

    // The strobe sees the post-ack state.
    if (accept) begin
      if (state_n == IDLE) begin
        sd_we_n   = cpu_we;
        sd_addr_n = cpu_addr;
        if (cpu_we) begin
          wb_valid_n = 1'b1;
          wb_addr_n  = cpu_addr;
          wb_data_n  = cpu_wdata;
          sd_wdata_n = cpu_wdata;
          cpu_wait_n = !POST;
          state_n    = WR;
        end else begin
          cpu_wait_n = 1'b1;
          state_n    = RD;
        end
      end else if (POST && state_n == WR && wb_valid_n) begin
        if (cpu_we) begin
          pend_valid_n = 1'b1;
          pend_addr_n  = cpu_addr;
          pend_data_n  = cpu_wdata;
          cpu_wait_n   = 1'b1;
        end else if (cpu_addr == wb_addr_n) begin
          cpu_rdata_n = wb_data_n;
        end else begin
          pend_addr_n = cpu_addr;
          cpu_wait_n  = 1'b1;
          state_n     = WR_RD;
        end
      end
    end

    // Requests rise only from a cycle where sd_req was low, which gives the
    // mandatory idle gap after every ack or abort.
    if (state_n != IDLE && !sd_req) begin
      sd_req_n = 1'b1;
      wd_cnt_n = 16'd0;
    end
  end

endmodule

// File: tb/tb_fastram_bridge.sv
// tb/tb_fastram_bridge.sv - self-checking bench for fastram_bridge
module tb_fastram_bridge;

`ifdef FASTRAM_WRITE_POST_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        strobe = 1'b0, cpu_ce = 1'b0, cpu_we = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait, sd_req, sd_we, timeout_err;
  logic [22:0] sd_addr;
  logic [7:0]  sd_wdata;
  logic        sd_ack = 1'b0;
  logic [7:0]  sd_rdata = 8'h00;

  fastram_bridge #(.ADDR_W(23), .TIMEOUT(8)) dut (
    .clk_sys(clk_sys), .reset(reset), .strobe(strobe), .cpu_ce(cpu_ce),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait), .sd_req(sd_req),
    .sd_we(sd_we), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_ack(sd_ack), .sd_rdata(sd_rdata), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic rst, stb, ce, we; logic [22:0] addr; logic [7:0] wd; logic ack; logic [7:0] rd;
    logic req, swe; logic [22:0] saddr; logic [7:0] swd; logic wt; logic [7:0] rdat; logic err;
  } vec_t;
  vec_t vecs[$];

  int n_pass = 0, n_total = 0;
  int gap_err = 0, stab_err = 0;
  bit auto_ack = 1'b0;
  int age = 0, dly = 1;
  logic prev_req = 1'b0;
  logic [31:0] prev_bus = '0;
  logic [7:0] sdram_mem [8];
  logic [7:0] ref_mem [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic row(input logic rst, stb, ce, we, input logic [22:0] addr, input logic [7:0] wd,
                     input logic ack, input logic [7:0] rd, input logic req, swe,
                     input logic [22:0] saddr, input logic [7:0] swd, input logic wt,
                     input logic [7:0] rdat, input logic err);
    vec_t v;
    v.rst = rst; v.stb = stb; v.ce = ce; v.we = we; v.addr = addr; v.wd = wd; v.ack = ack; v.rd = rd;
    v.req = req; v.swe = swe; v.saddr = saddr; v.swd = swd; v.wt = wt; v.rdat = rdat; v.err = err;
    vecs.push_back(v);
  endtask

  // One clock; lands at the negedge, runs protocol monitors and the SDRAM responder.
  task automatic tick();
    logic ack_was;
    ack_was = sd_ack;
    @(posedge clk_sys);
    @(negedge clk_sys);
    if (ack_was && sd_req) gap_err++;
    if (prev_req && sd_req && !ack_was && ({8'h00, sd_we, sd_addr} != prev_bus[31:0] || 1'b0)) stab_err++;
    prev_req = sd_req;
    prev_bus = {8'h00, sd_we, sd_addr};
    if (auto_ack) begin
      if (sd_ack) sd_ack = 1'b0;
      else if (sd_req) begin
        age++;
        if (age >= dly) begin
          sd_ack = 1'b1;
          if (sd_we) sdram_mem[sd_addr[2:0]] = sd_wdata;
          else sd_rdata = sdram_mem[sd_addr[2:0]];
          age = 0;
          dly = $urandom_range(1, 5);
        end
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!cpu_wait) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  initial begin
    bit ok;
    logic [7:0] d, expd;
    int idx;
    bit we, ce;

    // Common: reset, then read miss acked 3 cycles after sd_req rises.
    row(0,0,0,0,23'h0,8'h00,0,8'h00, 0,0,23'h0,8'h00,0,8'h00,0);
    row(1,1,1,0,23'h012345,8'h00,0,8'h00, 1,0,23'h012345,8'h00,1,8'h00,0);
    repeat (3) row(1,0,0,0,23'h0,8'h00,0,8'h00, 1,0,23'h012345,8'h00,1,8'h00,0);
    row(1,0,0,0,23'h0,8'h00,1,8'hA5, 0,0,23'h012345,8'h00,0,8'hA5,0);
`ifdef FASTRAM_WRITE_POST_EN
    // Posted write then same-address read forwarded.
    row(1,1,1,1,23'h000400,8'h3C,0,8'h00, 1,1,23'h000400,8'h3C,0,8'hA5,0);
    row(1,1,1,0,23'h000400,8'h00,0,8'h00, 1,1,23'h000400,8'h3C,0,8'h3C,0);
    row(1,0,0,0,23'h0,8'h00,1,8'h00, 0,1,23'h000400,8'h3C,0,8'h3C,0);
    // Write then different-address read: WR_RD, gap, then read.
    row(1,1,1,1,23'h000400,8'h11,0,8'h00, 1,1,23'h000400,8'h11,0,8'h3C,0);
    row(1,1,1,0,23'h000800,8'h00,0,8'h00, 1,1,23'h000400,8'h11,1,8'h3C,0);
    row(1,0,0,0,23'h0,8'h00,1,8'h00, 0,0,23'h000800,8'h11,1,8'h3C,0);
    row(1,0,0,0,23'h0,8'h00,0,8'h00, 1,0,23'h000800,8'h11,1,8'h3C,0);
    row(1,0,0,0,23'h0,8'h00,1,8'h5A, 0,0,23'h000800,8'h11,0,8'h5A,0);
    // Back-to-back writes, first ack withheld.
    row(1,1,1,1,23'h000100,8'h21,0,8'h00, 1,1,23'h000100,8'h21,0,8'h5A,0);
    row(1,1,1,1,23'h000200,8'h42,0,8'h00, 1,1,23'h000100,8'h21,1,8'h5A,0);
    repeat (3) row(1,0,0,0,23'h0,8'h00,0,8'h00, 1,1,23'h000100,8'h21,1,8'h5A,0);
    row(1,0,0,0,23'h0,8'h00,1,8'h00, 0,1,23'h000200,8'h42,0,8'h5A,0);
    row(1,0,0,0,23'h0,8'h00,0,8'h00, 1,1,23'h000200,8'h42,0,8'h5A,0);
    row(1,0,0,0,23'h0,8'h00,1,8'h00, 0,1,23'h000200,8'h42,0,8'h5A,0);
    // Ack and strobe in the same cycle: read sees the drained buffer.
    row(1,1,1,1,23'h000300,8'h66,0,8'h00, 1,1,23'h000300,8'h66,0,8'h5A,0);
    row(1,1,1,0,23'h000300,8'h00,1,8'h00, 0,0,23'h000300,8'h66,1,8'h5A,0);
    row(1,0,0,0,23'h0,8'h00,0,8'h00, 1,0,23'h000300,8'h66,1,8'h5A,0);
    row(1,0,0,0,23'h0,8'h00,1,8'h66, 0,0,23'h000300,8'h66,0,8'h66,0);
`else
    // Unposted write stalls until the cycle after ack; strobes meanwhile ignored.
    row(1,1,1,1,23'h000400,8'h3C,0,8'h00, 1,1,23'h000400,8'h3C,1,8'hA5,0);
    row(1,1,1,0,23'h000400,8'h00,0,8'h00, 1,1,23'h000400,8'h3C,1,8'hA5,0);
    row(1,0,0,0,23'h0,8'h00,1,8'h00, 0,1,23'h000400,8'h3C,0,8'hA5,0);
    row(1,1,1,0,23'h000400,8'h00,0,8'h00, 1,0,23'h000400,8'h3C,1,8'hA5,0);
    row(1,0,0,0,23'h0,8'h00,1,8'h3C, 0,0,23'h000400,8'h3C,0,8'h3C,0);
`endif
    // Watchdog on an unacked read, then reset mid-request with a late ack.
    row(0,0,0,0,23'h0,8'h00,0,8'h00, 0,0,23'h0,8'h00,0,8'h00,0);
    row(1,1,1,0,23'h000333,8'h00,0,8'h00, 1,0,23'h000333,8'h00,1,8'h00,0);
    repeat (7) row(1,0,0,0,23'h0,8'h00,0,8'h00, 1,0,23'h000333,8'h00,1,8'h00,0);
    row(1,0,0,0,23'h0,8'h00,0,8'h00, 0,0,23'h000333,8'h00,0,8'hFF,1);
    row(1,1,1,0,23'h000555,8'h00,0,8'h00, 1,0,23'h000555,8'h00,1,8'hFF,1);
    row(0,0,0,0,23'h0,8'h00,0,8'h00, 0,0,23'h0,8'h00,0,8'h00,0);
    row(1,0,0,0,23'h0,8'h00,1,8'h77, 0,0,23'h0,8'h00,0,8'h00,0);
    row(1,0,0,0,23'h0,8'h00,0,8'h00, 0,0,23'h0,8'h00,0,8'h00,0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; strobe = vecs[i].stb; cpu_ce = vecs[i].ce; cpu_we = vecs[i].we;
      cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wd; sd_ack = vecs[i].ack; sd_rdata = vecs[i].rd;
      tick();
      check($sformatf("vec%0d", i),
            {21'h0, sd_req, sd_we, sd_addr, sd_wdata, cpu_wait, cpu_rdata, timeout_err},
            {21'h0, vecs[i].req, vecs[i].swe, vecs[i].saddr, vecs[i].swd, vecs[i].wt, vecs[i].rdat, vecs[i].err});
    end

    // Randomized traffic against a flat-memory reference with an SDRAM responder.
    strobe = 1'b0; cpu_ce = 1'b0; sd_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sdram_mem[i] = 8'($urandom);
      ref_mem[i] = sdram_mem[i];
    end
    reset = 1'b0; tick(); reset = 1'b1;
    auto_ack = 1'b1; age = 0; dly = $urandom_range(1, 5);
    for (int n = 0; n < 300; n++) begin
      wait_ready(ok);
      if (!ok) check("rand_ready", {63'h0, cpu_wait}, 64'h0);
      repeat ($urandom_range(0, 2)) tick();
      idx = $urandom_range(0, 7);
      we = 1'($urandom_range(0, 1));
      ce = ($urandom_range(0, 9) != 0);
      d = 8'($urandom);
      strobe = 1'b1; cpu_ce = ce; cpu_we = we; cpu_addr = 23'h040000 | 23'(idx); cpu_wdata = d;
      tick();
      strobe = 1'b0; cpu_ce = 1'b0;
      if (ce) begin
        if (we) ref_mem[idx] = d;
        else begin
          expd = ref_mem[idx];
          wait_ready(ok);
          if (!ok) check("rand_rd_ready", {63'h0, cpu_wait}, 64'h0);
          check($sformatf("rand_rd%0d", n), {56'h0, cpu_rdata}, {56'h0, expd});
        end
      end
    end
    repeat (20) tick();
    for (int i = 0; i < 8; i++)
      check($sformatf("sdram_mem%0d", i), {56'h0, sdram_mem[i]}, {56'h0, ref_mem[i]});
    check("req_gap", 64'(gap_err), 64'h0);
    check("req_stable", 64'(stab_err), 64'h0);
    check("no_timeout", {63'h0, timeout_err}, 64'h0);
    check("drained", {62'h0, sd_req, cpu_wait}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fastram_bridge.md
# fastram_bridge

Sits between the core's fast-RAM request outputs (bank/address, write data, write enable, chip enable, sampled on the memory phase strobe) and the external SDRAM controller. It converts per-phase CPU accesses into a level request/acknowledge handshake and holds read data stable for the core. It adds a one-entry posted-write buffer with read-after-write forwarding, and drives `cpu_wait` while an access is outstanding. A watchdog aborts hung requests.

## Interface
Parameters:
- `ADDR_W`, 23: fast-RAM byte address width ({bank[6:0], addr}).
- `TIMEOUT`, 255: max cycles `sd_req` may stay high without `sd_ack`; range 2..65535.

Ports:
- `clk_sys`  in  1  system clock; sole clock.
- `reset`  in  1  synchronous, active-low reset.
- `strobe`  in  1  one-cycle memory-phase pulse (the `clk_div==2` phase); CPU inputs valid this cycle.
- `cpu_ce`  in  1  fast-RAM selected for this access.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  access address.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  read data; held until the next read completes.
- `cpu_wait`  out  1  stall request to the core.
- `sd_req`  out  1  request to SDRAM controller, held until ack.
- `sd_we`  out  1  request type; stable while `sd_req`=1.
- `sd_addr`  out  ADDR_W  request address; stable while `sd_req`=1.
- `sd_wdata`  out  8  write data; stable while `sd_req`=1.
- `sd_ack`  in  1  one-cycle completion pulse; read data valid the same cycle.
- `sd_rdata`  in  8  read data.
- `timeout_err`  out  1  sticky; set on watchdog abort, cleared only by reset.

## Operation
- Accesses are accepted only on `strobe`=1 with `cpu_ce`=1; other cycles are ignored. A strobe while `cpu_wait`=1 is a core protocol violation and is ignored.
- Write buffer: `wb_valid`, `wb_addr`, `wb_data`.
- States:
  - IDLE
  - WR: draining the write buffer.
  - RD: read outstanding.
  - WR_RD: draining the buffer, then reading.
- Write in IDLE: capture into buffer, go to WR, raise `sd_req` with `sd_we`=1. `cpu_wait` stays 0.
- Write in WR (buffer full): assert `cpu_wait`. The new write is captured in the cycle after `sd_ack` and a new WR starts. `cpu_wait` drops in that same cycle.
- Read, `wb_valid`=1 and `cpu_addr`==`wb_addr`: forward `wb_data` to `cpu_rdata` next cycle. No SDRAM request; `cpu_wait` stays 0.
- Read, `wb_valid`=1, address mismatch: go to WR_RD with `cpu_wait`=1. After the write ack, issue the read and go to RD.
- Read in IDLE: go to RD, `sd_req`=1, `sd_we`=0, `cpu_wait`=1.
- RD on `sd_ack`: latch `sd_rdata` into `cpu_rdata`, drop `sd_req`, return to IDLE.
- WR on `sd_ack`: clear `wb_valid`, return to IDLE, unless a stalled write is waiting.
- `sd_req` drops for at least one cycle between consecutive requests.
- Watchdog:
  - A counter runs while `sd_req`=1 and resets on each new request.
  - When it reaches `TIMEOUT`: drop `sd_req`, clear `wb_valid`, set `timeout_err`, return to IDLE.
  - A read aborted this way returns 8'hFF.
- Reset values: `sd_req`=0, `sd_we`=0, `sd_addr`=0, `sd_wdata`=0, `cpu_rdata`=8'h00, `cpu_wait`=0, `timeout_err`=0, `wb_valid`=0, state IDLE.
- Reset mid-request: `sd_req` drops the following cycle. An `sd_ack` for the abandoned request, arriving in IDLE, is ignored.

## Timing
- All outputs are registered.
- Strobe sampled at cycle T; `sd_req`/`cpu_wait` go high at T+1.
- Read miss with `sd_ack` at A: `cpu_rdata` is valid and `cpu_wait`=0 at A+1. Minimum read latency is 2 cycles (ack at T+1).
- Forwarded read: `cpu_rdata` is valid at T+1.
- WR_RD: write ack at A1, read `sd_req` high at A1+2 (one idle cycle), then the read-miss timing applies.
- An `sd_ack` in the same cycle as `strobe` is processed first; the strobe is then evaluated against the post-ack state.

## Configuration
- `FASTRAM_WRITE_POST_EN` defined: posted-write buffer and forwarding behave as above.
- Not defined: every write asserts `cpu_wait` from T+1 until the cycle after `sd_ack`. Forwarding logic is removed; WR_RD is unreachable.

## Test plan
- Read miss: read at 23'h012345, ack 3 cycles later with 8'hA5 -> `cpu_rdata`=8'hA5, `cpu_wait` high for exactly 4 cycles.
- Posted write then same-address read: write 8'h3C to 23'h000400, then read 23'h000400 before ack -> `cpu_rdata`=8'h3C at T+1, no read request, `cpu_wait`=0.
- Write then different-address read: write to 23'h000400, then read 23'h000800 -> write request first, then read request after a one-cycle gap, with `cpu_wait` held throughout.
- Back-to-back writes, ack withheld 5 cycles -> second write stalls, then is captured the cycle after ack; `sd_addr` shows the second address.
- Watchdog: `TIMEOUT`=8, no ack on a read -> `sd_req` drops after 8 cycles, `cpu_rdata`=8'hFF, `timeout_err`=1.
- Reset (low for 1 cycle) during RD -> outputs at reset values next cycle; a late `sd_ack` has no effect.
